// File: rtl/trng_source_if.sv
// rtl/trng_source_if.sv - request/word/valid handshake between TRNG source and its consumer
interface trng_source_if #(
  parameter int TRNG_WIDTH = 8
);
  logic                  trng_req;
  logic [TRNG_WIDTH-1:0] trng_word;
  logic                  trng_valid;

  // Producer side: drives the word and its valid pulse, listens to requests.
  modport master (
    input  trng_req,
    output trng_word,
    output trng_valid
  );

  // Consumer side.
  modport slave (
    output trng_req,
    input  trng_word,
    input  trng_valid
  );
endinterface

// File: rtl/trng_source.sv
// rtl/trng_source.sv - von Neumann conditioned TRNG with word FIFO and repetition health test
module trng_source #(
  parameter int TRNG_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             raw_bit,
  input  logic                             raw_strobe,
  trng_source_if.master                    io,
  output logic                             health_fail,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(TRNG_WIDTH);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(TRNG_WIDTH - 1);
  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
  localparam logic [RW-1:0] LIMIT    = RW'(REP_LIMIT);

  typedef enum logic {FIRST, SECOND} pair_t;
  typedef enum logic {IDLE, VALID} out_t;

  pair_t                  pair_state;
  logic                   b0;
  logic [TRNG_WIDTH-1:0]  acc;
  logic [CW-1:0]          bit_cnt;

  logic                   last_bit;
  logic                   seen;
  logic [RW-1:0]          run_cnt;
  logic [RW-1:0]          run_next;

  logic [TRNG_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  out_t                   out_state;
  logic [TRNG_WIDTH-1:0]  word_q;
  logic                   valid_q;

  logic                   trip;
  logic                   fail_now;
  logic                   emit;
  logic                   word_done;
  logic [TRNG_WIDTH-1:0]  full_word;
  logic                   pop;
  logic                   push;

  // Run length the health counter will hold after this strobe (saturating).
  always_comb begin
    run_next = RW'(1);
    if (seen && raw_bit == last_bit) begin
      run_next = (run_cnt == LIMIT) ? run_cnt : run_cnt + RW'(1);
    end
  end

  // A tripping sample blocks pushes and flushes the FIFO on the same edge.
  assign trip      = raw_strobe && (run_next == LIMIT);
  assign fail_now  = health_fail || trip;
  assign emit      = raw_strobe && (pair_state == SECOND) && (raw_bit != b0);
  assign word_done = emit && (bit_cnt == LAST_BIT);
  assign full_word = {b0, acc[TRNG_WIDTH-1:1]};
  assign pop       = (out_state == IDLE) && io.trng_req && (fifo_level != '0) && !health_fail;
  assign push      = word_done && !fail_now && ((fifo_level != FULL) || pop);

  assign io.trng_word  = word_q;
  assign io.trng_valid = valid_q;

  // Von Neumann pairing and LSB-first word packing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_state <= FIRST;
      b0         <= 1'b0;
      acc        <= '0;
      bit_cnt    <= '0;
    end else if (raw_strobe) begin
      if (pair_state == FIRST) begin
        b0         <= raw_bit;
        pair_state <= SECOND;
      end else begin
        pair_state <= FIRST;
        if (emit) begin
          acc     <= full_word;
          bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
        end
      end
    end
  end

  // Repetition-count health test; the failure flag is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_bit    <= 1'b0;
      seen        <= 1'b0;
      run_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (raw_strobe) begin
      last_bit <= raw_bit;
      seen     <= 1'b1;
      run_cnt  <= run_next;
      if (trip) health_fail <= 1'b1;
    end
  end

  // FIFO storage; pointers alone define validity so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= full_word;
  end

  // FIFO pointers and level; a health failure empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (fail_now) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_level <= fifo_level + LW'(1);
      else if (pop && !push) fifo_level <= fifo_level - LW'(1);
    end
  end

  // Output FSM: one-cycle valid per delivered word, word held until the next delivery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state <= IDLE;
      word_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (out_state)
        IDLE: begin
          if (pop) begin
            out_state <= VALID;
            word_q    <= mem[rd_ptr];
            valid_q   <= 1'b1;
          end
        end
        VALID: begin
          out_state <= IDLE;
          valid_q   <= 1'b0;
        end
        default: begin
          out_state <= IDLE;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trng_source.sv
// tb/tb_trng_source.sv - self-checking bench for trng_source
module tb_trng_source;
  logic       clk = 1'b0;
  logic       reset;
  logic       raw_bit;
  logic       raw_strobe;
  logic       health_fail;
  logic [2:0] fifo_level;

  trng_source_if #(.TRNG_WIDTH(8)) io ();

  trng_source #(.TRNG_WIDTH(8), .FIFO_DEPTH(4), .REP_LIMIT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_bit    (raw_bit),
    .raw_strobe (raw_strobe),
    .io         (io.master),
    .health_fail(health_fail),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = -10;
  int valid_cnt = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic [31:0] raw;
    int          nraw;
    logic [7:0]  exp_word;
    logic [2:0]  exp_level;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [7:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[15-2*i] = w[i];
      r[14-2*i] = ~w[i];
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every delivered word must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && io.trng_valid) begin
      valid_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid actual=0x%0h expected=none", io.trng_word);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (io.trng_word !== e) begin
          errors++;
          $display("FAIL word actual=0x%0h expected=0x%0h", io.trng_word, e);
        end
      end
      checks++;
      if (last_valid_cyc == cyc - 1) begin
        errors++;
        $display("FAIL back_to_back actual=%0d expected=%0d", cyc, last_valid_cyc + 2);
      end
      last_valid_cyc = cyc;
    end
  end

  task automatic strobe(input logic b);
    raw_bit = b;
    raw_strobe = 1'b1;
    @(posedge clk);
    #1;
    raw_strobe = 1'b0;
  endtask

  task automatic strobe_seq(input logic [31:0] raw, input int n);
    for (int i = n - 1; i >= 0; i--) strobe(raw[i]);
  endtask

  task automatic wait_drain(input int max);
    int c;
    c = 0;
    while (sb.size() != 0 && c < max) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, io.trng_valid, 0);
    chk({tag, "_word"}, io.trng_word, 0);
    chk({tag, "_health"}, health_fail, 0);
    chk({tag, "_level"}, fifo_level, 0);
  endtask

  vec_t vecs [5];
  logic [15:0] enc;

  initial begin
    vecs[0] = '{32'h9966, 16, 8'hA5, 3'd1};
    vecs[1] = '{32'h35AA5, 20, 8'h3C, 3'd1};
    vecs[2] = '{32'hAAAA, 16, 8'hFF, 3'd1};
    vecs[3] = '{32'h5555, 16, 8'h00, 3'd1};
    vecs[4] = '{32'h9556, 16, 8'h81, 3'd1};

    reset = 1'b1;
    raw_bit = 1'b0;
    raw_strobe = 1'b0;
    io.trng_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Word assembly and discarded pairs, table driven.
    foreach (vecs[k]) begin
      io.trng_req = 1'b0;
      strobe_seq(vecs[k].raw, vecs[k].nraw);
      chk($sformatf("vec%0d_level", k), fifo_level, vecs[k].exp_level);
      sb.push_back(vecs[k].exp_word);
      io.trng_req = 1'b1;
      wait_drain(20);
      io.trng_req = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_level_after", k), fifo_level, 0);
      chk($sformatf("vec%0d_word_hold", k), io.trng_word, vecs[k].exp_word);
    end

    // Full FIFO drops the fifth word; back-to-back draining on alternate cycles.
    for (int k = 1; k <= 5; k++) begin
      enc = encode(8'(k));
      strobe_seq({16'h0, enc}, 16);
      if (k <= 4) sb.push_back(8'(k));
    end
    chk("full_level", fifo_level, 4);
    io.trng_req = 1'b1;
    wait_drain(40);
    io.trng_req = 1'b0;
    @(posedge clk);
    #1;
    chk("full_drained_level", fifo_level, 0);

    // Push and pop on the same edge while full.
    for (int k = 1; k <= 4; k++) begin
      enc = encode(8'(k * 17));
      strobe_seq({16'h0, enc}, 16);
      sb.push_back(8'(k * 17));
    end
    chk("simul_full_level", fifo_level, 4);
    enc = encode(8'h99);
    for (int i = 15; i >= 1; i--) strobe(enc[i]);
    sb.push_back(8'h99);
    raw_bit = enc[0];
    raw_strobe = 1'b1;
    io.trng_req = 1'b1;
    @(posedge clk);
    #1;
    raw_strobe = 1'b0;
    chk("simul_level", fifo_level, 4);
    wait_drain(40);
    io.trng_req = 1'b0;
    @(posedge clk);
    #1;
    chk("simul_drained_level", fifo_level, 0);

    // Health failure with two words buffered.
    enc = encode(8'hFF);
    strobe_seq({16'h0, enc}, 16);
    enc = encode(8'h81);
    strobe_seq({16'h0, enc}, 16);
    chk("health_pre_level", fifo_level, 2);
    for (int i = 0; i < 15; i++) strobe(1'b1);
    chk("health_before_limit", health_fail, 0);
    chk("health_before_level", fifo_level, 2);
    strobe(1'b1);
    chk("health_tripped", health_fail, 1);
    chk("health_flushed", fifo_level, 0);
    begin
      int vc;
      vc = valid_cnt;
      io.trng_req = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      io.trng_req = 1'b0;
      chk("health_no_valid", valid_cnt, vc);
    end
    chk("health_sticky", health_fail, 1);
    reset = 1'b1;
    #1;
    chk("health_cleared", health_fail, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset mid-word discards the partial word; strobes during reset are ignored.
    strobe_seq(32'h0A5A, 12);
    reset = 1'b1;
    raw_strobe = 1'b1;
    raw_bit = 1'b1;
    #1;
    check_zero_outputs("midreset");
    @(posedge clk);
    #1;
    check_zero_outputs("midreset_edge");
    reset = 1'b0;
    raw_strobe = 1'b0;
    strobe_seq(32'h6699, 16);
    chk("midreset_level", fifo_level, 1);
    sb.push_back(8'h5A);
    io.trng_req = 1'b1;
    wait_drain(20);
    io.trng_req = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_word", io.trng_word, 8'h5A);
    chk("final_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/trng_source.md
# trng_source

Entropy-conditioning TRNG source that drives the producer side of the `trng_req` / `trng_word` / `trng_valid` handshake consumed by the SoC's TRNG I/O peripheral. It samples a raw noise bit stream and removes bias with a von Neumann corrector. It packs the corrected bits into `TRNG_WIDTH`-bit words and buffers them in a small FIFO, which it serves on request. A repetition-count health test permanently blocks output when the raw source appears stuck.

## Interface
- `TRNG_WIDTH`, 8: bits per output word; must be ≥2.
- `FIFO_DEPTH`, 4: number of buffered words; a power of two, ≥2.
- `REP_LIMIT`, 16: raw run length that trips the health test; ≥2.

Ports:
- `clk`  in  1  single clock; every flop is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `raw_bit`  in  1  raw noise sample; valid only while `raw_strobe` is high.
- `raw_strobe`  in  1  one raw sample per cycle in which it is high.
- `trng_req`  in  1  request from the consumer; level-sensitive.
- `trng_word`  out  TRNG_WIDTH  output word; meaningful only while `trng_valid` is high.
- `trng_valid`  out  1  one-cycle pulse that delivers `trng_word`.
- `health_fail`  out  1  sticky failure flag.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  number of words currently buffered.

## Operation
**Reset:** every output is 0. Reset also clears the FIFO, the pair state, the packing accumulator, the bit count and the health counters. Asserting `reset` mid-operation discards any partial word or pair immediately.

**Von Neumann corrector.** Two states, `FIRST` and `SECOND`, with reset state `FIRST`.
- In `FIRST`, a strobed sample stores `raw_bit` as `b0` and moves to `SECOND`.
- In `SECOND`, a strobed sample `b1` returns to `FIRST` and resolves the pair:
  - `b0,b1` = `1,0` emits a 1.
  - `b0,b1` = `0,1` emits a 0.
  - `0,0` and `1,1` emit nothing.

**Packing.**
- Each emitted bit shifts in as `acc <= {bit, acc[W-1:1]}` and increments the bit count.
- The first emitted bit of a word therefore ends in bit 0, and the last in bit W-1.
- When the W-th bit is emitted, the full word `{bit, acc[W-1:1]}` is pushed to the FIFO and the bit count clears, all in the same edge.
- If the FIFO is full and no pop happens in that cycle, the word is dropped silently and the count still clears.

**Output FSM.** Two states, `IDLE` and `VALID`.
- `IDLE` moves to `VALID` when `trng_req` is high, `fifo_level` ≠ 0 and `health_fail` is 0.
- On that edge `trng_word` is loaded with the FIFO head and the head is popped.
- `VALID` always returns to `IDLE` after one cycle. `trng_valid` is high exactly in `VALID`.
- `trng_word` holds its value until the next delivery.
- With `trng_req` held high, words are delivered at most every other cycle.
- Dropping `trng_req` while in `VALID` has no effect on the current delivery.

**Health test.**
- The health logic tracks the last raw bit and a run counter.
- On each strobe, a sample equal to the last bit increments the counter, saturating. A differing sample sets the counter to 1. The first sample after reset sets it to 1.
- When the counter reaches `REP_LIMIT`, `health_fail` is set. It is sticky until `reset`.
- While `health_fail` is set:
  - the FIFO is flushed (`fifo_level` reads 0),
  - no pushes occur,
  - the FSM stays in `IDLE`. A `VALID` already in progress completes normally.

**FIFO.**
- Circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`.
- A push and a pop in the same cycle are both accepted, including when the FIFO is full. `fifo_level` is unchanged in that case.

## Timing
- Strobe-to-push: the word enters the FIFO on the edge that samples the completing raw bit.
- Push-to-valid: `trng_valid` rises on the edge after the push when `trng_req` is already high. Earliest: completing strobe at edge N, push at N, `trng_valid` high from N+1 to N+2.
- `fifo_level` reflects pushes and pops on the same edge that performs them.
- `health_fail` rises on the edge that samples the `REP_LIMIT`-th identical bit.
- A word completing on that same edge is not pushed.
- `raw_strobe` is ignored entirely while `reset` is high.

## Test plan
- **Word assembly:** with `trng_req` = 0, strobe raw bits 1,0,0,1,1,0,0,1,0,1,1,0,0,1,1,0 → `fifo_level` = 1. Then raise `trng_req` → one-cycle `trng_valid` with `trng_word` = 0xA5, and `fifo_level` returns to 0.
- **Discard pairs:** strobe 0,0,1,1 and then 16 bits that encode 0x3C → exactly one word 0x3C is delivered; the 00 and 11 pairs contribute no bits.
- **Full FIFO and back-to-back:** with `trng_req` = 0, push 5 words 0x01–0x05 → `fifo_level` = 4 and 0x05 is dropped. Hold `trng_req` high → 0x01–0x04 are delivered with `trng_valid` on alternate cycles, and `fifo_level` ends at 0.
- **Simultaneous push/pop when full:** with `fifo_level` = 4 and `trng_req` high, complete a word on the same edge as the pop → `fifo_level` stays 4 and the new word is delivered last.
- **Health fail:** strobe 16 consecutive 1s (`REP_LIMIT` = 16) while 2 words are buffered → `health_fail` goes to 1 on the 16th strobe edge, `fifo_level` goes to 0, and `trng_valid` never asserts despite `trng_req`. Asserting `reset` clears `health_fail`.
- **Reset mid-word:** strobe 6 pairs, assert `reset` for 1 cycle, then strobe 8 pairs encoding 0x5A → the delivered word is 0x5A and all outputs read 0 during reset.
